// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data access unit: access-size encodings,
// FSM state type and the alignment rule.
package mem_pkg;

  typedef enum logic [2:0] {
    MOP_W  = 3'b000,
    MOP_H  = 3'b001,
    MOP_HU = 3'b010,
    MOP_B  = 3'b011,
    MOP_BU = 3'b100
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  function automatic logic op_is_half(input logic [2:0] op);
    return (op == MOP_H) || (op == MOP_HU);
  endfunction

  function automatic logic op_is_byte(input logic [2:0] op);
    return (op == MOP_B) || (op == MOP_BU);
  endfunction

  // Unused encodings fall through to the word rule.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
    if (op_is_byte(op)) return 1'b0;
    if (op_is_half(op)) return lo[0];
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: extracts/extends load data from a RAM word and builds the
// merged word written back for byte/half/word stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mb,
  input  logic [31:0] rd_word,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  be;
  logic [31:0] st_rep;

  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    case (mem_op)
      MOP_H:   ld_data = {{16{ld_half[15]}}, ld_half};
      MOP_HU:  ld_data = {16'h0000, ld_half};
      MOP_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      MOP_BU:  ld_data = {24'h000000, ld_byte};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    if (op_is_byte(mem_op)) begin
      be     = 4'b0001 << addr_lo;
      st_rep = {4{mb[7:0]}};
    end else if (op_is_half(mem_op)) begin
      be     = addr_lo[1] ? 4'b1100 : 4'b0011;
      st_rep = {2{mb[15:0]}};
    end else begin
      be     = 4'b1111;
      st_rep = mb;
    end

    st_word = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) st_word[8*i +: 8] = st_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data access unit: internal data RAM with a configurable wait-state
// model that stalls the upstream pipeline until the access completes.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mwmem,
  input  logic        mm2reg,
  input  logic [2:0]  mem_op,
  input  logic [31:0] maluout,
  input  logic [31:0] mb,
  output logic [31:0] data_out,
  output logic        mem_stall,
  output logic        mem_misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ram_q [DEPTH];

  logic [AW-1:0] widx;
  logic          req, misal, valid, done, stall, ram_we;
  logic [31:0]   rd_word, ld_data, st_word;
  logic          unused_hi;

  // Addresses wrap modulo DEPTH words; upper address bits carry no meaning here.
  assign widx      = maluout[AW+1:2];
  assign unused_hi = ^maluout[31:AW+2];
  assign rd_word   = ram_q[widx];

  mem_lane_align u_align (
    .mem_op  (mem_op),
    .addr_lo (maluout[1:0]),
    .mb      (mb),
    .rd_word (rd_word),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_comb begin
    req     = mwmem | mm2reg;
    misal   = req & misaligned(mem_op, maluout[1:0]);
    valid   = req & ~misal;
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    stall   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          if (WAIT_CYCLES == 0) begin
            done = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = ST_BUSY;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_BUSY: begin
        if (!valid) begin
          // Request flushed away while waiting: drop the access.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    mem_stall    = stall & ~rst;
    mem_misalign = misal & ~rst;
    data_out     = (!rst && valid && mm2reg && !mwmem) ? ld_data : 32'h0;
    ram_we       = done & mwmem & ~rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[widx] <= st_word;
  end

endmodule
